// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer driving one shared micro-rotation stage.
// A request is latched, then the stage is fed once per iteration with the
// current x/y/angle, the arithmetic-shifted x/y and the atan table entry.
// Stage results are written back only when the stage marks them valid.
// After N_ITER accepted results the final x/y/angle are offered downstream.
//
// Handshakes: both the request port (in_valid/in_ready) and the result port
// (out_valid/out_ready) transfer on a rising clock edge where valid and ready
// are both high. Ready never depends on valid. Once out_valid is raised, it
// stays high and out_x/out_y/out_angle stay unchanged until the transfer.
module cordic_iter_ctrl #(
    parameter int N_ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_angle,
    input  logic [31:0] in_target,
    input  logic [3:0]  in_select,
    output logic [31:0] alu_x_init,
    output logic [31:0] alu_y_init,
    output logic [31:0] alu_x_shift,
    output logic [31:0] alu_y_shift,
    output logic [31:0] alu_angle,
    output logic [31:0] alu_delta_angle,
    output logic [31:0] alu_target_angle,
    output logic [3:0]  alu_select,
    output logic        alu_valid,
    input  logic [31:0] alu_x_out,
    input  logic [31:0] alu_y_out,
    input  logic [31:0] alu_angle_out,
    input  logic        alu_valid_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_angle,
    output logic        busy,
    output logic [4:0]  iter
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'(N_ITER - 1);

    // atan(2^-i) as a fraction of a full turn scaled to 2^32, rounded.
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:  v = 32'h20000000;
            5'd1:  v = 32'h12E4051E;
            5'd2:  v = 32'h09FB385B;
            5'd3:  v = 32'h051111D4;
            5'd4:  v = 32'h028B0D43;
            5'd5:  v = 32'h0145D7E1;
            5'd6:  v = 32'h00A2F61E;
            5'd7:  v = 32'h00517C55;
            5'd8:  v = 32'h0028BE53;
            5'd9:  v = 32'h00145F2F;
            5'd10: v = 32'h000A2F98;
            5'd11: v = 32'h000517CC;
            5'd12: v = 32'h00028BE6;
            5'd13: v = 32'h000145F3;
            5'd14: v = 32'h0000A2FA;
            5'd15: v = 32'h0000517D;
            5'd16: v = 32'h000028BE;
            5'd17: v = 32'h0000145F;
            5'd18: v = 32'h00000A30;
            5'd19: v = 32'h00000518;
            5'd20: v = 32'h0000028C;
            5'd21: v = 32'h00000146;
            5'd22: v = 32'h000000A3;
            5'd23: v = 32'h00000051;
            5'd24: v = 32'h00000029;
            5'd25: v = 32'h00000014;
            5'd26: v = 32'h0000000A;
            5'd27: v = 32'h00000005;
            5'd28: v = 32'h00000003;
            5'd29: v = 32'h00000001;
            5'd30: v = 32'h00000001;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  iter_q, iter_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] angle_q, angle_d;
    logic [31:0] target_q, target_d;
    logic [3:0]  select_q, select_d;
    logic        alu_valid_c;
    logic        out_valid_c;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            iter_q   <= 5'd0;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            angle_q  <= 32'd0;
            target_q <= 32'd0;
            select_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            x_q      <= x_d;
            y_q      <= y_d;
            angle_q  <= angle_d;
            target_q <= target_d;
            select_q <= select_d;
        end
    end

    // Next-state, register updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        x_d         = x_q;
        y_d         = y_q;
        angle_d     = angle_q;
        target_d    = target_q;
        select_d    = select_q;
        alu_valid_c = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d      = in_x;
                    y_d      = in_y;
                    angle_d  = in_angle;
                    target_d = in_target;
                    select_d = in_select;
                    iter_d   = 5'd0;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                alu_valid_c = 1'b1;
                // A stage result without alu_valid_out is a stall: hold all.
                if (alu_valid_out) begin
                    x_d     = alu_x_out;
                    y_d     = alu_y_out;
                    angle_d = alu_angle_out;
                    iter_d  = iter_q + 5'd1;
                    if (iter_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is withheld while reset is asserted so nothing is lost in reset.
    assign in_ready         = (state_q == S_IDLE) && !rst;
    assign alu_valid        = alu_valid_c;
    assign out_valid        = out_valid_c;
    assign busy             = (state_q != S_IDLE);
    assign iter             = iter_q;

    assign alu_x_init       = x_q;
    assign alu_y_init       = y_q;
    assign alu_x_shift      = $signed(x_q) >>> iter_q;
    assign alu_y_shift      = $signed(y_q) >>> iter_q;
    assign alu_angle        = angle_q;
    assign alu_delta_angle  = atan_lut(iter_q);
    assign alu_target_angle = target_q;
    assign alu_select       = select_q;

    assign out_x            = x_q;
    assign out_y            = y_q;
    assign out_angle        = angle_q;

endmodule
